key_search_collector: RTL
=========================

# key_search_collector

Collects status from the parallel RC4 brute-force decryption cores and declares the search outcome. Latches the secret key of the first core to report a successful decryption and broadcasts `outer_finish` to stop the remaining cores. Declares failure once every core has exhausted its key range. Drives the board's status LEDs and six 7-segment digits showing the winning key.

## Interface
Parameters:
- `NUM_CORES`, 8, number of decryption cores observed.
- `KEY_WIDTH`, 24, width of each core's secret key.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `core_finish`  in  NUM_CORES  per-core "message decrypted with valid characters" flag.
- `core_not_found`  in  NUM_CORES  per-core "key range exhausted" flag.
- `core_secret`  in  NUM_CORES x KEY_WIDTH  each core's current secret key.
- `outer_finish`  out  1  stop broadcast to all cores.
- `found`  out  1  search succeeded.
- `all_failed`  out  1  every core exhausted its range.
- `winning_key`  out  KEY_WIDTH  latched key of the winning core.
- `winning_core`  out  $clog2(NUM_CORES)  index of the winning core.
- `search_cycles`  out  32  clock cycles spent in SEARCH, saturating.
- `hex_digits`  out  6 x 7  active-low 7-segment patterns of `winning_key`; digit 5 shows the MS nibble.

## Operation
- FSM states: SEARCH, FOUND, FAILED. FOUND and FAILED are absorbing until `reset`.
- **SEARCH**
  - If any `core_finish` bit is high: select the lowest-index set bit `i` (fixed priority).
  - On that edge: `winning_key` <= `core_secret[i]`, `winning_core` <= `i`, `found` <= 1, `outer_finish` <= 1. Next state FOUND.
  - Sticky register `failed_mask[i]` sets whenever `core_not_found[i]` is high. It never clears except on `reset`.
  - If every bit of `failed_mask | core_not_found` is 1 and no `core_finish` is high: `all_failed` <= 1, `outer_finish` <= 1. Next state FAILED.
  - `search_cycles` increments by 1 each SEARCH cycle and saturates at 32'hFFFF_FFFF.
- **FOUND / FAILED**
  - All inputs ignored.
  - Outputs frozen, including `search_cycles`.
  - `winning_key` does not follow later changes on `core_secret`.
- Simultaneous events:
  - `core_finish` wins over any `core_not_found`, on the same core or on others.
  - Several `core_finish` bits high together: lowest index wins.
- `hex_digits` decode registered `winning_key` nibbles 0-F combinationally and show all zeros until FOUND.
- Reset values: state SEARCH, `outer_finish`=0, `found`=0, `all_failed`=0, `winning_key`=0, `winning_core`=0, `search_cycles`=0, `failed_mask`=0.
- Reset mid-operation, in any state: all registers return to their reset values on the next edge. Search restarts with a fresh count.

## Timing
- Flags are sampled on the rising edge of `clk`.
- `found`, `all_failed`, `outer_finish`, `winning_key` and `winning_core` are registered. They become visible exactly 1 cycle after the sampling edge where the event was seen.
- `core_secret[i]` is captured on the same edge that samples `core_finish[i]`. A core advancing its key on that edge does not corrupt the latched value.
- `hex_digits` follows `winning_key` with no additional register stage.
- No combinational path from any input to any output.

## Structure
- Shared package `rc4_search_pkg`:
  - `search_state_t` enum (SEARCH, FOUND, FAILED).
  - `KEY_WIDTH` and default `NUM_CORES` constants.
  - Active-low 7-segment constant table for hex digits 0-F.
- Sub-module `hex_to_seven_seg`: one 4-bit nibble in, one 7-bit pattern out. Instantiated 6 times.
- Priority select, failure mask and cycle counter live in the top module.

## Test plan
- After `reset`, hold all flags low for 100 cycles → state SEARCH, `outer_finish`=0, `search_cycles`=100.
- `core_secret[3]`=24'h0003C2, pulse `core_finish[3]` for 1 cycle → next cycle `found`=1, `outer_finish`=1, `winning_key`=24'h0003C2, `winning_core`=3, `hex_digits` shows "0003C2". Values hold after the flag drops and after `core_secret[3]` changes.
- Raise `core_finish[5]` and `core_finish[2]` in the same cycle → `winning_core`=2 and the key from core 2.
- Raise `core_not_found` on cores 0..6 one at a time over several cycles, then core 7 → `all_failed`=1 and `outer_finish`=1 one cycle after core 7's flag. `found`=0.
- Raise `core_not_found`=all ones and `core_finish[4]` in the same cycle → FOUND with `winning_core`=4, `all_failed`=0.
- In FOUND, assert `reset` for 1 cycle → all outputs at reset values, `search_cycles` restarts at 0. A following `core_finish[1]` gives a new win.

Source files
------------

// File: rtl/key_search_collector_pkg.sv
// Shared types and constants for the RC4 key-search result collector.
package rc4_search_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    FOUND  = 2'd1,
    FAILED = 2'd2
  } search_state_t;

  localparam int RC4_KEY_WIDTH = 24;
  localparam int RC4_NUM_CORES = 8;

  // Active-low segments {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/key_search_collector_if.sv
// Bundle between the decryption cores (master side) and the result collector (slave side).
interface key_search_collector_if
  import rc4_search_pkg::*;
#(
  parameter int NUM_CORES = RC4_NUM_CORES,
  parameter int KEY_WIDTH = RC4_KEY_WIDTH
) ();
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [NUM_CORES-1:0]                core_finish;
  logic [NUM_CORES-1:0]                core_not_found;
  logic [NUM_CORES-1:0][KEY_WIDTH-1:0] core_secret;
  logic                                outer_finish;
  logic                                found;
  logic                                all_failed;
  logic [KEY_WIDTH-1:0]                winning_key;
  logic [IDX_W-1:0]                    winning_core;
  logic [31:0]                         search_cycles;
  logic [5:0][6:0]                     hex_digits;

  modport master (
    output core_finish, core_not_found, core_secret,
    input  outer_finish, found, all_failed, winning_key, winning_core,
           search_cycles, hex_digits
  );

  modport slave (
    input  core_finish, core_not_found, core_secret,
    output outer_finish, found, all_failed, winning_key, winning_core,
           search_cycles, hex_digits
  );
endinterface

// File: rtl/key_search_collector_hex_to_seven_seg.sv
// One hex nibble to one active-low 7-segment pattern.
module hex_to_seven_seg
  import rc4_search_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);
  assign seg_o = SEG_TABLE[nibble_i];
endmodule

// File: rtl/key_search_collector.sv
// Declares the search outcome from per-core status flags, latches the winning key
// and drives the stop broadcast plus the six-digit key display.
module key_search_collector
  import rc4_search_pkg::*;
#(
  parameter int NUM_CORES = RC4_NUM_CORES,
  parameter int KEY_WIDTH = RC4_KEY_WIDTH
) (
  input logic                 clk,
  input logic                 reset,
  key_search_collector_if.slave bus
);
  localparam int IDX_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int DISP_W = 24;

  search_state_t        state_q, state_d;
  logic                 outer_finish_q, outer_finish_d;
  logic                 found_q, found_d;
  logic                 all_failed_q, all_failed_d;
  logic [KEY_WIDTH-1:0] winning_key_q, winning_key_d;
  logic [IDX_W-1:0]     winning_core_q, winning_core_d;
  logic [31:0]          search_cycles_q, search_cycles_d;
  logic [NUM_CORES-1:0] failed_mask_q, failed_mask_d;

  logic                 any_finish_s;
  logic                 exhausted_s;
  logic [IDX_W-1:0]     win_idx_s;
  logic [DISP_W-1:0]    disp_key_s;
  logic [5:0][6:0]      hex_s;

  assign any_finish_s = |bus.core_finish;
  assign exhausted_s  = &(failed_mask_q | bus.core_not_found);

  // Fixed-priority select: scanning downwards leaves the lowest set index.
  always_comb begin
    win_idx_s = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      win_idx_s = bus.core_finish[i] ? IDX_W'(i) : win_idx_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEARCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a finish always beats exhaustion in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH: begin
        if (any_finish_s) begin
          state_d = FOUND;
        end else if (exhausted_s) begin
          state_d = FAILED;
        end else begin
          state_d = SEARCH;
        end
      end
      FOUND:   state_d = FOUND;
      FAILED:  state_d = FAILED;
      default: state_d = SEARCH;
    endcase
  end

  // Output/datapath next values; everything holds once a verdict is reached.
  always_comb begin
    outer_finish_d  = outer_finish_q;
    found_d         = found_q;
    all_failed_d    = all_failed_q;
    winning_key_d   = winning_key_q;
    winning_core_d  = winning_core_q;
    search_cycles_d = search_cycles_q;
    failed_mask_d   = failed_mask_q;
    case (state_q)
      SEARCH: begin
        search_cycles_d = (search_cycles_q == 32'hFFFF_FFFF) ? search_cycles_q
                                                             : search_cycles_q + 32'd1;
        failed_mask_d   = failed_mask_q | bus.core_not_found;
        if (any_finish_s) begin
          winning_key_d  = bus.core_secret[win_idx_s];
          winning_core_d = win_idx_s;
          found_d        = 1'b1;
          outer_finish_d = 1'b1;
        end else if (exhausted_s) begin
          all_failed_d   = 1'b1;
          outer_finish_d = 1'b1;
        end else begin
          outer_finish_d = outer_finish_q;
        end
      end
      FOUND:   outer_finish_d = outer_finish_q;
      FAILED:  outer_finish_d = outer_finish_q;
      default: outer_finish_d = 1'b0;
    endcase
  end

  // Result and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      outer_finish_q  <= 1'b0;
      found_q         <= 1'b0;
      all_failed_q    <= 1'b0;
      winning_key_q   <= '0;
      winning_core_q  <= '0;
      search_cycles_q <= 32'd0;
      failed_mask_q   <= '0;
    end else begin
      outer_finish_q  <= outer_finish_d;
      found_q         <= found_d;
      all_failed_q    <= all_failed_d;
      winning_key_q   <= winning_key_d;
      winning_core_q  <= winning_core_d;
      search_cycles_q <= search_cycles_d;
      failed_mask_q   <= failed_mask_d;
    end
  end

  assign disp_key_s = DISP_W'(winning_key_q);

  for (genvar g = 0; g < 6; g++) begin : g_hex
    hex_to_seven_seg u_hex (
      .nibble_i (disp_key_s[4*g +: 4]),
      .seg_o    (hex_s[g])
    );
  end

  assign bus.outer_finish  = outer_finish_q;
  assign bus.found         = found_q;
  assign bus.all_failed    = all_failed_q;
  assign bus.winning_key   = winning_key_q;
  assign bus.winning_core  = winning_core_q;
  assign bus.search_cycles = search_cycles_q;
  assign bus.hex_digits    = hex_s;

endmodule
